// File: rtl/phv_out_fifo.sv
// phv_out_fifo: elastic PHV buffer between the last match-action stage and the deparser.
//   axis_clk/aresetn          : clock, asynchronous active-low reset
//   phv_in/phv_in_valid       : PHV strobe from the stage chain (no backpressure)
//   phv_out/_valid/_ready     : in-order head-of-buffer handshake to the deparser
//   almost_full, level        : registered watermark and current occupancy
//   drop_cnt                  : saturating count of PHVs refused while full
module phv_out_fifo #(
  parameter int PHV_LEN    = 1024+7+24*8+5*20+256,
  parameter int DEPTH_BITS = 4,
  parameter int AF_MARGIN  = 4
) (
  input  logic                  axis_clk,
  input  logic                  aresetn,
  input  logic [PHV_LEN-1:0]    phv_in,
  input  logic                  phv_in_valid,
  output logic [PHV_LEN-1:0]    phv_out,
  output logic                  phv_out_valid,
  input  logic                  phv_out_ready,
  output logic                  almost_full,
  output logic [DEPTH_BITS:0]   level,
  output logic [31:0]           drop_cnt
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  logic [PHV_LEN-1:0]    mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   level_q, level_d;
  logic [31:0]           drop_cnt_q, drop_cnt_d;
  logic                  almost_full_q, almost_full_d;
  logic                  push, pop, drop;
  always_comb begin
    pop           = (|level_q) & phv_out_ready;
    // a pop in the same cycle frees a slot, so a full buffer still accepts
    push          = phv_in_valid & ((level_q < (DEPTH_BITS+1)'(DEPTH)) | pop);
    drop          = phv_in_valid & ~push;
    wr_ptr_d      = push ? wr_ptr_q + DEPTH_BITS'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + DEPTH_BITS'(1) : rd_ptr_q;
    level_d       = level_q + (DEPTH_BITS+1)'(push) - (DEPTH_BITS+1)'(pop);
    almost_full_d = level_d >= (DEPTH_BITS+1)'(DEPTH - AF_MARGIN);
    drop_cnt_d    = (drop & ~&drop_cnt_q) ? drop_cnt_q + 32'd1 : drop_cnt_q;
  end
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      drop_cnt_q    <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      drop_cnt_q    <= drop_cnt_d;
      almost_full_q <= almost_full_d;
    end
  end
  // storage is deliberately not reset; phv_out is meaningless while empty
  always_ff @(posedge axis_clk) begin
    if (push) mem[wr_ptr_q] <= phv_in;
  end
  assign phv_out       = mem[rd_ptr_q];
  assign phv_out_valid = |level_q;
  assign almost_full   = almost_full_q;
  assign level         = level_q;
  assign drop_cnt      = drop_cnt_q;
endmodule

// File: doc/phv_out_fifo.md
# phv_out_fifo

Elastic PHV buffer sitting directly downstream of the last match-action stage and upstream of the deparser. The stage chain has no backpressure, so this block absorbs each PHV emitted on the stage's `phv_out`/`phv_out_valid` into a circular buffer. It presents the PHVs in order to the deparser over a valid/ready handshake. It raises an almost-full watermark so the parser front end can throttle, and it drops and counts PHVs that arrive when the buffer has no room.

## Interface
- `PHV_LEN`, default 1024+7+24*8+5*20+256 (1579): PHV width in bits; must match the stage chain.
- `DEPTH_BITS`, default 4: log2 of the entry count; DEPTH = 2^DEPTH_BITS = 16.
- `AF_MARGIN`, default 4: `almost_full` asserts when free entries ≤ AF_MARGIN; legal range 1..DEPTH-1.

- `axis_clk`  in  1  sole clock; all logic on the rising edge.
- `aresetn`  in  1  reset; asynchronous assert, active-low.
- `phv_in`  in  PHV_LEN  PHV from the last stage's `phv_out`.
- `phv_in_valid`  in  1  one-cycle strobe; `phv_in` is valid this cycle. There is no ready signal on this side.
- `phv_out`  out  PHV_LEN  head-of-buffer PHV to the deparser.
- `phv_out_valid`  out  1  the buffer is non-empty and `phv_out` holds the oldest entry.
- `phv_out_ready`  in  1  the deparser accepts `phv_out` this cycle.
- `almost_full`  out  1  level ≥ DEPTH-AF_MARGIN; registered.
- `level`  out  DEPTH_BITS+1  current occupancy, 0..DEPTH.
- `drop_cnt`  out  32  count of dropped PHVs; saturates at 0xFFFFFFFF.

## Operation
- Storage is DEPTH×PHV_LEN entries with a write pointer and a read pointer, each DEPTH_BITS wide and wrapping modulo DEPTH. A `level` counter of DEPTH_BITS+1 bits determines full and empty; the pointers alone are never compared.
- pop = `phv_out_valid` & `phv_out_ready`.
- push = `phv_in_valid` & (level < DEPTH | pop). When the buffer is full and a pop happens in the same cycle, the incoming PHV is accepted, because the pop frees a slot.
- drop = `phv_in_valid` & ~push. On a drop, `drop_cnt` increments by 1 unless it already holds 0xFFFFFFFF; it never wraps. Storage and pointers are unchanged by a drop.
- On a push, the entry at the write pointer is written with `phv_in` and the write pointer advances by 1. On a pop, the read pointer advances by 1.
- `level` update: +1 on push only, -1 on pop only, unchanged on both or neither.
- `phv_out` = entry at the read pointer. `phv_out_valid` = (level ≠ 0). While `phv_out_valid`=1 and `phv_out_ready`=0, `phv_out` holds stable.
- `almost_full` is a register loaded each cycle from the next value of `level` compared against DEPTH-AF_MARGIN.
- Ordering: PHVs leave in strict arrival order. No PHV is duplicated or reordered. A drop never corrupts a stored entry.
- Pop on empty is impossible, because `phv_out_valid`=0; `phv_out_ready` is ignored while the buffer is empty.

## Timing
- Reset, asynchronous while `aresetn`=0:
  - pointers, `level`, `drop_cnt` = 0; `phv_out_valid`=0; `almost_full`=0.
  - Storage is not reset, so `phv_out` is don't-care while `phv_out_valid`=0.
- Latency: a PHV pushed in cycle N into an empty buffer appears on `phv_out` with `phv_out_valid`=1 in cycle N+1. It is not visible combinationally in cycle N.
- Throughput: one push and one pop per cycle, sustained.
- `level` and `almost_full` reflect all pushes and pops through the previous edge.
- Reset asserted mid-stream: all buffered PHVs are discarded and `drop_cnt` clears. After deassertion, the first accepted PHV appears one cycle after its push, as from empty.
- `drop_cnt` changes on the edge following the dropping cycle.

## Test plan
- Single PHV: push one PHV with `phv_out_ready`=0.
  - Next cycle: `phv_out_valid`=1, `phv_out` matches the pushed PHV, `level`=1.
  - Then hold ready=1 for one cycle: `level`=0 and `phv_out_valid`=0 on the next cycle.
- Fill and watermark: push 16 distinct PHVs (tag in bits [15:0] = 0..15) with ready=0.
  - `almost_full` rises the cycle after the 12th push; `level`=16 after the 16th.
  - Drain with ready=1: tags come out 0..15 in order.
- Overflow: with the buffer full and ready=0, assert `phv_in_valid` for 3 cycles.
  - `drop_cnt`=3; `level` stays 16; the drained contents still read 0..15.
- Full plus simultaneous pop/push: with the buffer full, assert ready=1 and push tag 99 in the same cycle.
  - `drop_cnt` unchanged; `level` stays 16; tag 99 emerges 16th from the drain.
- Wrap-around under random traffic: run 1000 cycles with random `phv_in_valid` (50%) and `phv_out_ready` (70%).
  - A scoreboard confirms order and content.
  - Accepted count minus popped count equals `level` every cycle; `drop_cnt` equals the model's drop count.
- Reset mid-operation: with `level`=7 and `drop_cnt`=2, pulse `aresetn` low for a non-edge-aligned interval.
  - `phv_out_valid`, `level`, `drop_cnt` and `almost_full` go to 0 immediately.
  - After release, a new push appears one cycle later.
